// File: rtl/phrase_playback_engine_pkg.sv
// playback_pkg: shared state encoding and offset-binary PWM helpers for the phrase playback engine.
package playback_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, FILL = 2'd1, PLAY = 2'd2, FULL = 2'd3} pb_state_t;
  localparam logic [7:0] PWM_MID = 8'h80;
  // Left-justify the sample so 8- and 16-bit widths share one MSB-flip conversion.
  function automatic logic [7:0] to_pwm8(input logic [15:0] sample, input int width);
    logic [15:0] t;
    t = sample << (16 - width);
    return {~t[15], t[14:8]};
  endfunction
endpackage

// File: rtl/phrase_playback_engine_if.sv
// phrase_playback_engine_if: AXIS-style phrase stream (tvalid/tready/tdata/tuser) into the playback engine.
interface phrase_playback_engine_if #(parameter int PHRASE_WIDTH = 128);
  logic                    valid;
  logic                    ready;
  logic                    tuser;
  logic [PHRASE_WIDTH-1:0] data;
  modport master(output valid, data, tuser, input ready);
  modport slave(input valid, data, tuser, output ready);
endinterface

// File: rtl/phrase_playback_engine_tick_gen.sv
// sample_tick_gen: frame-rate divider; tick_out is high in the cycle the counter reaches PERIOD-1.
module sample_tick_gen #(
  parameter int PERIOD = 8333
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable_in,
  output logic tick_out
);
  localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;
  assign last     = cnt_q == CW'(PERIOD - 1);
  assign tick_out = enable_in & last;
  assign cnt_d    = (!enable_in || last) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/phrase_playback_engine.sv
// phrase_playback_engine: double-buffered AXIS phrase unpacker emitting one PCM frame per sample tick.
// Define PLAYBACK_UNDERRUN_CNT_EN to build the saturating underrun counter; otherwise the count reads 0.
module phrase_playback_engine
  import playback_pkg::*;
#(
  parameter int PHRASE_WIDTH = 128,
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_CHANNELS = 1,
  parameter int CLOCK_SPEED  = 100_000_000,
  parameter int SAMPLE_RATE  = 12_000
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 enable_in,
  phrase_playback_engine_if.slave              phrase_if,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_out,
  output logic [NUM_CHANNELS*8-1:0]            pwm_level_out,
  output logic                                 sample_valid_out,
  output logic                                 rollover_out,
  output logic                                 underrun_out,
  output logic [15:0]                          underrun_count_out,
  output logic [1:0]                           state_out
);
  localparam int FW     = SAMPLE_WIDTH * NUM_CHANNELS;
  localparam int FRAMES = PHRASE_WIDTH / FW;
  localparam int IW     = FRAMES > 1 ? $clog2(FRAMES) : 1;
  localparam int PERIOD = CLOCK_SPEED / SAMPLE_RATE;

  logic                      tick;
  logic                      ready_q, act_v_q, pend_v_q, act_tuser_q, pend_tuser_q;
  logic [PHRASE_WIDTH-1:0]   act_data_q, pend_data_q;
  logic [IW-1:0]             idx_q;
  pb_state_t                 state_q;
  logic                      xfer, consume, last, promote, act_v_d, pend_v_d;
  logic [FW-1:0]             frame;
  logic [NUM_CHANNELS*8-1:0] pwm_frame;

  sample_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .enable_in(enable_in),
    .tick_out (tick)
  );

  assign xfer     = phrase_if.valid & ready_q;
  assign consume  = tick & act_v_q;
  assign last     = idx_q == IW'(FRAMES - 1);
  // Pending moves up when active is idle, or seamlessly as the last frame is consumed.
  assign promote  = pend_v_q & (!act_v_q | (consume & last));
  assign act_v_d  = promote | (act_v_q & !(consume & last));
  assign pend_v_d = xfer | (pend_v_q & !promote);
  assign frame    = FW'(act_data_q >> (int'(idx_q) * FW));

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pwm
    assign pwm_frame[c*8 +: 8] = to_pwm8(16'(frame >> (c * SAMPLE_WIDTH)), SAMPLE_WIDTH);
  end

  assign phrase_if.ready = ready_q;
  assign state_out       = state_q;

  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      ready_q          <= 1'b0;
      act_v_q          <= 1'b0;
      pend_v_q         <= 1'b0;
      act_tuser_q      <= 1'b0;
      pend_tuser_q     <= 1'b0;
      act_data_q       <= '0;
      pend_data_q      <= '0;
      idx_q            <= '0;
      state_q          <= EMPTY;
      sample_out       <= '0;
      pwm_level_out    <= '0;
      sample_valid_out <= 1'b0;
      rollover_out     <= 1'b0;
      underrun_out     <= 1'b0;
    end else begin
      ready_q          <= !pend_v_d;
      act_v_q          <= act_v_d;
      pend_v_q         <= pend_v_d;
      state_q          <= pb_state_t'({act_v_d, pend_v_d});
      if (xfer) begin
        pend_data_q  <= phrase_if.data;
        pend_tuser_q <= phrase_if.tuser;
      end
      if (promote) begin
        act_data_q  <= pend_data_q;
        act_tuser_q <= pend_tuser_q;
        idx_q       <= '0;
      end else if (consume) idx_q <= last ? '0 : idx_q + 1'b1;
      sample_valid_out <= consume;
      rollover_out     <= consume & (idx_q == '0) & act_tuser_q;
      underrun_out     <= tick & !act_v_q;
      if (tick) begin
        sample_out    <= act_v_q ? frame : '0;
        pwm_level_out <= act_v_q ? pwm_frame : {NUM_CHANNELS{PWM_MID}};
      end
    end

`ifdef PLAYBACK_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in)                                 ucnt_q <= '0;
    else if (tick & !act_v_q & (ucnt_q != 16'hFFFF)) ucnt_q <= ucnt_q + 1'b1;
  assign underrun_count_out = ucnt_q;
`else
  assign underrun_count_out = '0;
`endif
endmodule

// File: tb/tb_phrase_playback_engine.sv
// tb_phrase_playback_engine: scoreboard bench for an 8-bit mono and a 16-bit stereo engine (PERIOD=10).
module tb_phrase_playback_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  typedef struct { logic [31:0] s; logic [15:0] p; bit r; } exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;

  logic        rst_na = 1'b1, en_a = 1'b0, sva, roa, ura;
  logic [7:0]  sa, pwa;
  logic [15:0] cnta;
  logic [1:0]  sta;
  logic        rst_nb = 1'b1, en_b = 1'b0, svb, rob, urb;
  logic [31:0] sb;
  logic [15:0] pwb, cntb;
  logic [1:0]  stb;

  int rel_a = 1 << 30, rel_b = 1 << 30, last_a, last_b, urun_a = 0, urun_b = 0, nsv_a = 0;
  bit gap_a = 0, gap_b = 0, full_b = 0;

  phrase_playback_engine_if #(.PHRASE_WIDTH(128)) pa ();
  phrase_playback_engine_if #(.PHRASE_WIDTH(128)) pb ();

  phrase_playback_engine #(.PHRASE_WIDTH(128), .SAMPLE_WIDTH(8), .NUM_CHANNELS(1),
                           .CLOCK_SPEED(100), .SAMPLE_RATE(10)) dut_a (
    .clk_in(clk), .rst_in(rst_na), .enable_in(en_a), .phrase_if(pa),
    .sample_out(sa), .pwm_level_out(pwa), .sample_valid_out(sva), .rollover_out(roa),
    .underrun_out(ura), .underrun_count_out(cnta), .state_out(sta));

  phrase_playback_engine #(.PHRASE_WIDTH(128), .SAMPLE_WIDTH(16), .NUM_CHANNELS(2),
                           .CLOCK_SPEED(100), .SAMPLE_RATE(10)) dut_b (
    .clk_in(clk), .rst_in(rst_nb), .enable_in(en_b), .phrase_if(pb),
    .sample_out(sb), .pwm_level_out(pwb), .sample_valid_out(svb), .rollover_out(rob),
    .underrun_out(urb), .underrun_count_out(cntb), .state_out(stb));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef PLAYBACK_UNDERRUN_CNT_EN
    return 16'(n > 65535 ? 65535 : n);
`else
    return 16'(n & 0);
`endif
  endfunction

  // Reference model: every frame of an accepted phrase is queued in playback order.
  task automatic push_a(input logic [127:0] d, input bit tu);
    exp_t e;
    int   v;
    for (int f = 0; f < 16; f++) begin
      v   = int'((d >> (8 * f)) & 128'hFF);
      e.s = 32'(v);
      e.p = 16'((v + 128) % 256);
      e.r = (f == 0) && tu;
      qa.push_back(e);
    end
  endtask

  task automatic push_b(input logic [127:0] d, input bit tu);
    exp_t e;
    int   s0, s1;
    for (int f = 0; f < 4; f++) begin
      s0  = int'((d >> (32 * f)) & 128'hFFFF);
      s1  = int'((d >> (32 * f + 16)) & 128'hFFFF);
      e.s = (32'(s1) << 16) | 32'(s0);
      e.p = 16'(((s1 + 32768) % 65536) / 256 * 256 + ((s0 + 32768) % 65536) / 256);
      e.r = (f == 0) && tu;
      qb.push_back(e);
    end
  endtask

  always @(negedge clk) if (rst_na && cyc > rel_a) begin
    check("a_ready_vs_state", pa.ready, !sta[0]);
    if (sva || ura) begin
      check("a_tick_while_paused", en_a, 1);
      if (gap_a) check("a_tick_gap", cyc - last_a, 10);
      last_a = cyc;
      gap_a  = 1;
    end
    if (sva) begin
      nsv_a++;
      check("a_frame_expected", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("a_sample", sa, ea.s);
        check("a_pwm", pwa, ea.p);
        check("a_rollover", roa, ea.r);
      end
    end
    if (ura) begin
      urun_a++;
      check("a_urun_pending_frames", qa.size(), 0);
      check("a_urun_sample", sa, 0);
      check("a_urun_pwm", pwa, 8'h80);
      check("a_urun_valid", sva, 0);
      check("a_urun_count", cnta, cnt_exp(urun_a));
    end
  end

  always @(negedge clk) if (rst_nb && cyc > rel_b) begin
    check("b_ready_vs_state", pb.ready, !stb[0]);
    if (stb == 2'd3) full_b = 1;
    if (svb || urb) begin
      if (gap_b) check("b_tick_gap", cyc - last_b, 10);
      last_b = cyc;
      gap_b  = 1;
    end
    if (svb) begin
      check("b_frame_expected", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("b_sample", sb, eb.s);
        check("b_pwm", pwb, eb.p);
        check("b_rollover", rob, eb.r);
      end
    end
    if (urb) begin
      urun_b++;
      check("b_urun_pending_frames", qb.size(), 0);
      check("b_urun_sample", sb, 0);
      check("b_urun_pwm", pwb, 16'h8080);
      check("b_urun_count", cntb, cnt_exp(urun_b));
    end
  end

  task automatic wait_ev(input int which, input int budget, input string nm);
    bit hit = 0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      hit = which == 0 ? sva : which == 1 ? ura : which == 2 ? (sva | ura) : urb;
    end
    check(nm, hit, 1);
  endtask

  task automatic send_a(input logic [127:0] d, input bit tu);
    int k = 0;
    @(posedge clk); #1;
    pa.valid = 1'b1; pa.data = d; pa.tuser = tu;
    while (!pa.ready && k < 300) begin @(posedge clk); #1; k++; end
    check("a_accept", pa.ready, 1);
    if (pa.ready) push_a(d, tu);
    @(posedge clk); #1;
    pa.valid = 1'b0;
  endtask

  task automatic chk_rst_a(input string t);
    check({t, "_sample"}, sa, 0);
    check({t, "_pwm"}, pwa, 0);
    check({t, "_valid"}, sva, 0);
    check({t, "_rollover"}, roa, 0);
    check({t, "_underrun"}, ura, 0);
    check({t, "_count"}, cnta, 0);
    check({t, "_state"}, sta, 0);
    check({t, "_ready"}, pa.ready, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic run_a();
    logic [127:0] d;
    int n0, c0;
    pa.valid = 1'b0; pa.data = '0; pa.tuser = 1'b0;
    #1 rst_na = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_rst_a("a_por");
    rst_na = 1'b1; rel_a = cyc;
    @(posedge clk); #1;
    check("a_ready_after_rst", pa.ready, 1);
    check("a_state_after_rst", sta, 0);
    en_a = 1'b1;
    send_a(128'h0F0E0D0C0B0A09080706050403020100, 1'b1);
    wait_ev(1, 400, "a_t1_underrun");
    check("a_t1_strobes", nsv_a, 16);
    check("a_t1_state_empty", sta, 0);
    wait_ev(2, 20, "a_tick_before_batch");
    d = rnd128();
    d[15:0] = 16'h7F80;
    send_a(d, 1'b1);
    for (int p = 0; p < 2; p++) send_a(rnd128(), 1'($urandom_range(0, 1)));
    wait_ev(1, 1200, "a_batch_underrun");
    wait_ev(2, 20, "a_tick_before_pause");
    send_a(rnd128(), 1'b0);
    for (int s = 0; s < 3; s++) wait_ev(0, 40, "a_pre_pause_frame");
    @(posedge clk); #1;
    en_a = 1'b0; gap_a = 0; n0 = nsv_a;
    repeat (37) @(posedge clk);
    check("a_pause_strobes", nsv_a - n0, 0);
    #1 en_a = 1'b1; c0 = cyc;
    wait_ev(0, 30, "a_resume_frame");
    check("a_resume_delay", cyc - c0, 10);
    wait_ev(1, 400, "a_pause_underrun");
    wait_ev(2, 20, "a_tick_before_reset");
    send_a(rnd128(), 1'b0);
    send_a(rnd128(), 1'b1);
    for (int s = 0; s < 5; s++) wait_ev(0, 40, "a_pre_reset_frame");
    @(posedge clk); #1 rst_na = 1'b0;
    #1 chk_rst_a("a_mid_rst");
    qa.delete(); urun_a = 0; gap_a = 0;
    @(posedge clk); #1 rst_na = 1'b1; rel_a = cyc;
    send_a(rnd128(), 1'b1);
    wait_ev(0, 40, "a_post_rst_frame");
    wait_ev(1, 400, "a_post_rst_underrun");
  endtask

  task automatic run_b();
    logic [127:0] d;
    int k;
    pb.valid = 1'b0; pb.data = '0; pb.tuser = 1'b0;
    #1 rst_nb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_nb = 1'b1; rel_b = cyc;
    @(posedge clk); #1;
    en_b = 1'b1; pb.valid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      d = rnd128();
      if (p == 0) d[31:0] = 32'h8000_7FFF;
      pb.data = d; pb.tuser = (p == 0);
      k = 0;
      while (!pb.ready && k < 300) begin @(posedge clk); #1; k++; end
      check("b_accept", pb.ready, 1);
      push_b(d, p == 0);
      @(posedge clk); #1;
    end
    pb.valid = 1'b0;
    wait_ev(3, 400, "b_final_underrun");
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    check("b_full_seen", full_b, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
